// File: rtl/mac_sequencer.sv
// Streams two vectors as read beats into a multiply-accumulate datapath and
// captures its dot-product result, tracking in-flight reads and protocol errors.
module mac_sequencer #(
  parameter int unsigned VECTOR_SIZE     = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              clkIn,
  input  logic                              rstIn,
  input  logic                              startIn,
  input  logic [LEN_WIDTH-1:0]              lengthIn,
  input  logic [ADDR_WIDTH-1:0]             addrAIn,
  input  logic [ADDR_WIDTH-1:0]             addrBIn,
  output logic                              busyOut,
  output logic                              doneOut,
  output logic [DATA_WIDTH-1:0]             resultOut,
  output logic                              rdReqOut,
  output logic [ADDR_WIDTH-1:0]             rdAddrAOut,
  output logic [ADDR_WIDTH-1:0]             rdAddrBOut,
  input  logic                              rdGntIn,
  input  logic                              rdValidIn,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] rdDataAIn,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] rdDataBIn,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] macDataAOut,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] macDataBOut,
  output logic [VECTOR_SIZE-1:0]            macValidOut,
  output logic                              macLastOut,
  input  logic [DATA_WIDTH-1:0]             macResultIn,
  input  logic                              macResultValidIn,
  output logic                              errorOut
);

  localparam int unsigned BUS_W = VECTOR_SIZE * DATA_WIDTH;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_RES, DONE} state_t;

  state_t                state, state_n;
  logic [LEN_WIDTH-1:0]  beats, beats_n, issued, issued_n, returned, returned_n;
  logic [OUT_W-1:0]      outstanding, outstanding_n;
  logic [ADDR_WIDTH-1:0] addr_a, addr_a_n, addr_b, addr_b_n;
  logic [VECTOR_SIZE-1:0] last_mask, last_mask_n;

  logic                   busy_n, done_n, rd_req_n, mac_last_n, error_n;
  logic [DATA_WIDTH-1:0]  result_n;
  logic [ADDR_WIDTH-1:0]  rd_addr_a_n, rd_addr_b_n;
  logic [BUS_W-1:0]       mac_data_a_n, mac_data_b_n;
  logic [VECTOR_SIZE-1:0] mac_valid_n;

  logic [LEN_WIDTH-1:0]   len_rem, beats_c;
  logic [VECTOR_SIZE-1:0] mask_c;
  logic                   accept, ret_ok;

  // Job geometry: beat count and the lane mask used on the final beat.
  always_comb begin
    len_rem = lengthIn % LEN_WIDTH'(VECTOR_SIZE);
    beats_c = (lengthIn / LEN_WIDTH'(VECTOR_SIZE)) + LEN_WIDTH'(len_rem != '0);
    mask_c  = '0;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      mask_c[i] = (len_rem == '0) || (LEN_WIDTH'(i) < len_rem);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n      = state;
    beats_n      = beats;
    issued_n     = issued;
    returned_n   = returned;
    addr_a_n     = addr_a;
    addr_b_n     = addr_b;
    last_mask_n  = last_mask;
    result_n     = resultOut;
    error_n      = errorOut;
    mac_data_a_n = '0;
    mac_data_b_n = '0;
    mac_valid_n  = '0;
    mac_last_n   = 1'b0;

    accept = (state == RUN) && rdReqOut && rdGntIn;
    ret_ok = rdValidIn && (outstanding != '0);

    // Protocol violations are flagged and otherwise dropped.
    if (rdValidIn && !ret_ok) error_n = 1'b1;
    if (macResultValidIn && (state != WAIT_RES)) error_n = 1'b1;

    case (state)
      IDLE: begin
        if (startIn) begin
          addr_a_n    = addrAIn;
          addr_b_n    = addrBIn;
          beats_n     = beats_c;
          last_mask_n = mask_c;
          issued_n    = '0;
          returned_n  = '0;
          if (lengthIn == '0) begin
            result_n = '0;
            state_n  = DONE;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (accept) issued_n = issued + LEN_WIDTH'(1);
        if (ret_ok) begin
          returned_n   = returned + LEN_WIDTH'(1);
          mac_data_a_n = rdDataAIn;
          mac_data_b_n = rdDataBIn;
          mac_last_n   = (returned_n == beats);
          mac_valid_n  = mac_last_n ? last_mask : '1;
          if (mac_last_n) state_n = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (macResultValidIn) begin
          result_n = macResultIn;
          state_n  = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    outstanding_n = outstanding + OUT_W'(accept) - OUT_W'(ret_ok);

    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
    rd_req_n    = (state_n == RUN) && (issued_n < beats_n) &&
                  (outstanding_n < OUT_W'(MAX_OUTSTANDING));
    rd_addr_a_n = rd_req_n ? addr_a_n + ADDR_WIDTH'(issued_n) : '0;
    rd_addr_b_n = rd_req_n ? addr_b_n + ADDR_WIDTH'(issued_n) : '0;
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state       <= IDLE;
      beats       <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
      addr_a      <= '0;
      addr_b      <= '0;
      last_mask   <= '0;
      busyOut     <= 1'b0;
      doneOut     <= 1'b0;
      resultOut   <= '0;
      rdReqOut    <= 1'b0;
      rdAddrAOut  <= '0;
      rdAddrBOut  <= '0;
      macDataAOut <= '0;
      macDataBOut <= '0;
      macValidOut <= '0;
      macLastOut  <= 1'b0;
      errorOut    <= 1'b0;
    end else begin
      state       <= state_n;
      beats       <= beats_n;
      issued      <= issued_n;
      returned    <= returned_n;
      outstanding <= outstanding_n;
      addr_a      <= addr_a_n;
      addr_b      <= addr_b_n;
      last_mask   <= last_mask_n;
      busyOut     <= busy_n;
      doneOut     <= done_n;
      resultOut   <= result_n;
      rdReqOut    <= rd_req_n;
      rdAddrAOut  <= rd_addr_a_n;
      rdAddrBOut  <= rd_addr_b_n;
      macDataAOut <= mac_data_a_n;
      macDataBOut <= mac_data_b_n;
      macValidOut <= mac_valid_n;
      macLastOut  <= mac_last_n;
      errorOut    <= error_n;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized bench for mac_sequencer: a memory responder, a dot-product
// datapath model and per-scenario tasks checking against them.
module tb_mac_sequencer;

  localparam int unsigned V  = 8;
  localparam int unsigned D  = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned MO = 4;
  localparam int unsigned BW = V * D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          startIn;
  logic [LW-1:0] lengthIn;
  logic [AW-1:0] addrAIn, addrBIn;
  logic          busyOut, doneOut;
  logic [D-1:0]  resultOut;
  logic          rdReqOut;
  logic [AW-1:0] rdAddrAOut, rdAddrBOut;
  logic          rdGntIn, rdValidIn;
  logic [BW-1:0] rdDataAIn, rdDataBIn, macDataAOut, macDataBOut;
  logic [V-1:0]  macValidOut;
  logic          macLastOut;
  logic [D-1:0]  macResultIn;
  logic          macResultValidIn;
  logic          errorOut;

  always #5 clk = ~clk;

  mac_sequencer #(.VECTOR_SIZE(V), .DATA_WIDTH(D), .LEN_WIDTH(LW),
                  .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clkIn(clk), .rstIn(rst_n), .startIn(startIn), .lengthIn(lengthIn),
    .addrAIn(addrAIn), .addrBIn(addrBIn), .busyOut(busyOut), .doneOut(doneOut),
    .resultOut(resultOut), .rdReqOut(rdReqOut), .rdAddrAOut(rdAddrAOut),
    .rdAddrBOut(rdAddrBOut), .rdGntIn(rdGntIn), .rdValidIn(rdValidIn),
    .rdDataAIn(rdDataAIn), .rdDataBIn(rdDataBIn), .macDataAOut(macDataAOut),
    .macDataBOut(macDataBOut), .macValidOut(macValidOut), .macLastOut(macLastOut),
    .macResultIn(macResultIn), .macResultValidIn(macResultValidIn), .errorOut(errorOut)
  );

  typedef struct packed {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [V-1:0]  mask;
    logic          last;
  } beat_t;

  typedef struct packed {
    int            ready;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } ret_t;

  beat_t        exp_q[$];
  ret_t         ret_q[$];
  logic [V-1:0] mask_log[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int job_len = 0, lat = 2, gnt_pct = 100;
  logic [AW-1:0] job_a = '0, job_b = '0;
  int job_acc = 0, outst = 0, max_outst = 0, req_cycles = 0, beats_seen = 0, last_ret = 0;
  logic [D-1:0] acc = '0, exp_result = '0;
  bit res_pending = 0, res_drv = 0, val_drv = 0;
  int res_at = 0;

  // Memory responder and MAC datapath model, one step per falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (macValidOut != '0 || macLastOut) begin
        beats_seen++;
        mask_log.push_back(macValidOut);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mac_beat: unexpected beat mask=%h last=%b", macValidOut, macLastOut);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ({macDataAOut, macDataBOut, macValidOut, macLastOut} !== {e.a, e.b, e.mask, e.last}) begin
            n_err++;
            $display("FAIL mac_beat: got mask=%h last=%b a0=%h, want mask=%h last=%b a0=%h",
                     macValidOut, macLastOut, macDataAOut[D-1:0], e.mask, e.last, e.a[D-1:0]);
          end
          for (int i = 0; i < V; i++)
            if (e.mask[i]) acc = acc + e.a[i*D +: D] * e.b[i*D +: D];
          if (e.last) begin
            res_pending = 1;
            res_at = cyc + int'($urandom_range(0, 3));
          end
        end
      end
      if (rdReqOut) req_cycles++;
      if (outst >= MO) begin
        n_vec++;
        if (rdReqOut !== 1'b0) begin
          n_err++;
          $display("FAIL outstanding_limit: rdReqOut=%b with %0d outstanding, want 0", rdReqOut, outst);
        end
      end
      rdGntIn = (int'($urandom_range(0, 99)) < gnt_pct);
      if (rdReqOut && rdGntIn) begin
        logic [AW-1:0] ea, eb;
        logic [BW-1:0] da, db;
        logic [V-1:0]  m;
        int nb, rem, rdy;
        ea = job_a + AW'(job_acc);
        eb = job_b + AW'(job_acc);
        n_vec++;
        if (rdAddrAOut !== ea || rdAddrBOut !== eb) begin
          n_err++;
          $display("FAIL rd_addr: got %h/%h, want %h/%h", rdAddrAOut, rdAddrBOut, ea, eb);
        end
        for (int i = 0; i < V; i++) begin
          da[i*D +: D] = $urandom;
          db[i*D +: D] = $urandom;
        end
        rdy = cyc + lat;
        if (rdy <= last_ret) rdy = last_ret + 1;
        last_ret = rdy;
        ret_q.push_back('{ready: rdy, a: da, b: db});
        nb  = (job_len + V - 1) / V;
        rem = job_len % V;
        if (job_acc == nb - 1 && rem != 0) m = V'((1 << rem) - 1);
        else m = '1;
        exp_q.push_back('{a: da, b: db, mask: m, last: (job_acc == nb - 1)});
        job_acc++;
        outst++;
        if (outst > max_outst) max_outst = outst;
      end
      if (ret_q.size() > 0 && ret_q[0].ready <= cyc) begin
        ret_t r;
        r = ret_q.pop_front();
        rdValidIn = 1'b1;
        rdDataAIn = r.a;
        rdDataBIn = r.b;
        outst--;
        val_drv = 1;
      end else if (val_drv) begin
        rdValidIn = 1'b0;
        val_drv = 0;
      end
      if (res_pending && cyc >= res_at) begin
        macResultValidIn = 1'b1;
        macResultIn = acc;
        exp_result = acc;
        res_pending = 0;
        res_drv = 1;
      end else if (res_drv) begin
        macResultValidIn = 1'b0;
        res_drv = 0;
      end
    end
  end

  task automatic check_all_zero(input string name);
    n_vec++;
    if ({busyOut, doneOut, resultOut, rdReqOut, rdAddrAOut, rdAddrBOut, macDataAOut,
         macDataBOut, macValidOut, macLastOut, errorOut} !== '0) begin
      n_err++;
      $display("FAIL %s: outputs not all zero (busy=%b done=%b res=%h req=%b valid=%h err=%b)",
               name, busyOut, doneOut, resultOut, rdReqOut, macValidOut, errorOut);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    ret_q.delete();
    outst = 0;
    res_pending = 0;
  endtask

  task automatic run_job(input int len, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input int l, input int g, input bit mid_start);
    int done_i, nb;
    bit seen;
    job_len = len; job_a = a; job_b = b; lat = l; gnt_pct = g;
    job_acc = 0; acc = '0; exp_result = '0; beats_seen = 0; req_cycles = 0; max_outst = 0;
    mask_log.delete();
    nb = (len + V - 1) / V;
    @(negedge clk);
    startIn = 1'b1; lengthIn = LW'(len); addrAIn = a; addrBIn = b;
    @(negedge clk);
    startIn = 1'b0;
    n_vec++;
    if (busyOut !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start: got %b, want 1", busyOut);
    end
    seen = 0; done_i = -1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (doneOut === 1'b1) begin
        seen = 1; done_i = i;
      end else begin
        if (mid_start && i == 2) begin
          startIn = 1'b1; lengthIn = LW'(5); addrAIn = AW'($urandom); addrBIn = AW'($urandom);
        end else if (mid_start && i == 3) begin
          startIn = 1'b0;
          n_vec++;
          if (busyOut !== 1'b1) begin
            n_err++; $display("FAIL busy_mid_start: got %b, want 1", busyOut);
          end
        end
        @(negedge clk);
      end
    end
    startIn = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL done_timeout: len=%0d doneOut=0 after 3000 cycles, want pulse", len);
    end
    n_vec++;
    if (resultOut !== (len == 0 ? '0 : exp_result)) begin
      n_err++; $display("FAIL result: len=%0d got %h, want %h", len, resultOut, exp_result);
    end
    n_vec++;
    if (beats_seen != nb || exp_q.size() != 0 || errorOut !== 1'b0) begin
      n_err++;
      $display("FAIL beat_count: len=%0d got %0d beats (%0d left, err=%b), want %0d (0 left, err=0)",
               len, beats_seen, exp_q.size(), errorOut, nb);
    end
    if (len == 0) begin
      n_vec++;
      if (req_cycles != 0 || done_i != 0) begin
        n_err++;
        $display("FAIL zero_len: req cycles=%0d done at %0d, want 0 and 0", req_cycles, done_i);
      end
    end
    @(negedge clk);
    n_vec++;
    if (doneOut !== 1'b0 || busyOut !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b busy=%b after DONE, want 0/0", doneOut, busyOut);
    end
  endtask

  task automatic check_masks(input string name, input logic [V-1:0] m0, input logic [V-1:0] m1);
    n_vec++;
    if (mask_log.size() != 2 || mask_log[0] !== m0 || mask_log[1] !== m1) begin
      n_err++;
      $display("FAIL %s: got %0d masks first=%h second=%h, want %h then %h", name,
               mask_log.size(), (mask_log.size() > 0) ? mask_log[0] : '0,
               (mask_log.size() > 1) ? mask_log[1] : '0, m0, m1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_job(16, 16'h0100, 16'h0200, 2, 100, 0);
    check_masks("masks_len16", 8'hFF, 8'hFF);
  endtask

  task automatic test_partial();
    run_job(11, 16'h0040, 16'h0080, 2, 100, 0);
    check_masks("masks_len11", 8'hFF, 8'h07);
  endtask

  task automatic test_zero_len();
    run_job(0, 16'h1111, 16'h2222, 2, 100, 0);
  endtask

  task automatic test_back_to_back();
    run_job(64, 16'h3000, 16'h4000, 10, 100, 0);
    n_vec++;
    if (max_outst != MO) begin
      n_err++; $display("FAIL max_outstanding: got %0d, want %0d", max_outst, MO);
    end
  endtask

  task automatic test_wrap_and_start();
    run_job(16, 16'hFFFF, 16'h7FFF, 2, 100, 1);
  endtask

  task automatic test_error_result();
    logic [D-1:0] prev;
    prev = resultOut;
    @(negedge clk);
    macResultValidIn = 1'b1; macResultIn = 32'hDEADBEEF;
    @(negedge clk);
    macResultValidIn = 1'b0;
    @(negedge clk);
    n_vec++;
    if (errorOut !== 1'b1 || resultOut !== prev || busyOut !== 1'b0) begin
      n_err++;
      $display("FAIL stray_result: err=%b res=%h busy=%b, want 1/%h/0", errorOut, resultOut, busyOut, prev);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midjob();
    job_len = 64; job_a = 16'h5000; job_b = 16'h6000; lat = 10; gnt_pct = 100;
    job_acc = 0; acc = '0;
    @(negedge clk);
    startIn = 1'b1; lengthIn = LW'(64); addrAIn = job_a; addrBIn = job_b;
    @(negedge clk);
    startIn = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midjob");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    res_pending = 0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (errorOut !== 1'b1 || busyOut !== 1'b0) begin
      n_err++; $display("FAIL late_return: err=%b busy=%b, want 1/0", errorOut, busyOut);
    end
    rst_n = 1'b0;
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_job(int'($urandom_range(0, 70)), AW'($urandom), AW'($urandom),
              int'($urandom_range(1, 6)), int'($urandom_range(30, 100)), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; startIn = 1'b0; lengthIn = '0; addrAIn = '0; addrBIn = '0;
    rdGntIn = 1'b0; rdValidIn = 1'b0; rdDataAIn = '0; rdDataBIn = '0;
    macResultIn = '0; macResultValidIn = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_zero_len();
    test_back_to_back();
    test_wrap_and_start();
    test_error_result();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
